uart_tx_buffered: RTL and testbench

//   Buffered 8N1/8E1 UART transmitter. The transmit-side counterpart to the uart_receiver path.

---
 rtl/uart_tx_buffered.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes enter a FIFO on a valid/ready handshake and are
// serialised LSB first as 8N1 (or 8E1 with PARITY_EN) at CLKS_PER_BIT clocks per bit.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic                        clk,
    input  logic                        i_reset_n,
    input  logic [7:0]                  i_data,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic                        o_tx,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic          push;
    logic          pop;
    logic          baud_done;
    logic          enters_idle;

    assign o_ready      = (count != FULL_COUNT);
    assign o_fifo_count = count;
    assign push         = i_valid && o_ready;
    assign baud_done    = (baud_cnt == BAUD_LAST);

    // A pop happens only where the line is free to start a new frame.
    assign pop         = (count != '0) && ((state == IDLE) || (state == STOP && baud_done));
    assign enters_idle = !pop && ((state == IDLE) || (state == STOP && baud_done));

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + (AW+1)'(1);
        end else if (pop && !push) begin
            count_next = count - (AW+1)'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and count alone say what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            o_tx       <= 1'b1;
            o_busy     <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            o_busy <= !enters_idle || (count_next != '0);
            if (pop) begin
                shift_reg  <= mem[rd_ptr];
                parity_bit <= ^mem[rd_ptr];
            end
            case (state)
                IDLE: begin
                    o_tx     <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (pop) begin
                        state <= START;
                        o_tx  <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt  <= '0;
                        state     <= DATA;
                        o_tx      <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            if (PARITY_EN) begin
                                state <= PARITY;
                                o_tx  <= parity_bit;
                            end else begin
                                state <= STOP;
                                o_tx  <= 1'b1;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            o_tx      <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                PARITY: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        o_tx     <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        // Chain straight into the next start bit when a byte is waiting.
                        if (pop) begin
                            state <= START;
                            o_tx  <= 1'b0;
                        end else begin
                            state <= IDLE;
                            o_tx  <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    o_tx  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: constant frame table, FIFO corner sequences, mid-frame
// reset and a randomized stream decoded by an independent line monitor.
module tb_uart_tx_buffered;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic        s;
        logic [7:0]  data;
        logic [10:0] bits;
        int          nbits;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    tb_data = 8'h00;
    logic          tb_valid = 1'b0;
    logic          sel = 1'b0;
    logic          valid0, valid1;
    logic          ready0, tx0, busy0, ready1, tx1, busy1;
    logic [CW-1:0] cnt0, cnt1;
    logic          tx_s, busy_s, ready_s;
    logic [CW-1:0] cnt_s;

    int checks = 0;
    int errors = 0;

    assign valid0  = tb_valid & ~sel;
    assign valid1  = tb_valid & sel;
    assign tx_s    = sel ? tx1 : tx0;
    assign busy_s  = sel ? busy1 : busy0;
    assign ready_s = sel ? ready1 : ready0;
    assign cnt_s   = sel ? cnt1 : cnt0;

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .i_reset_n(rst_n), .i_data(tb_data), .i_valid(valid0),
        .o_ready(ready0), .o_tx(tx0), .o_busy(busy0), .o_fifo_count(cnt0)
    );

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .i_reset_n(rst_n), .i_data(tb_data), .i_valid(valid1),
        .o_ready(ready1), .o_tx(tx1), .o_busy(busy1), .o_fifo_count(cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Line image of one frame, bit 0 first on the wire.
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic par);
        if (par) return {1'b1, ^d, d, 1'b0};
        return {1'b0, 1'b1, d, 1'b0};
    endfunction

    // Single-cycle push; call at a negedge, returns at the negedge after the push edge.
    task automatic push1(input logic [7:0] d);
        tb_data  = d;
        tb_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tb_valid = 1'b0;
    endtask

    // Waits for a start bit, then demands the frames of q back to back, cycle by cycle.
    task automatic expect_frames(input bq_t q, input logic par, input int timeout);
        int          w;
        int          nb;
        logic [10:0] f;
        w  = 0;
        nb = par ? 11 : 10;
        while (tx_s !== 1'b0 && w < timeout) begin
            @(negedge clk);
            w++;
        end
        if (tx_s !== 1'b0) begin
            check("frame_start_seen", tx_s, 0);
            return;
        end
        foreach (q[b]) begin
            f = frame_bits(q[b], par);
            for (int k = 0; k < nb; k++) begin
                for (int c = 0; c < CPB; c++) begin
                    check($sformatf("frame%0d_bit%0d", b, k), tx_s, f[k]);
                    @(negedge clk);
                end
            end
        end
    endtask

    // Reference UART receiver on dut0's line: mid-bit sampling, compared to the accepted-byte queue.
    logic [7:0] exp_q[$];
    logic [7:0] mon_byte;
    int         mon_seen = 0;
    bit         mon_en = 1'b0;

    always begin
        @(negedge clk);
        if (mon_en && tx0 === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            check("mon_start_bit", tx0, 0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mon_byte[i] = tx0;
            end
            repeat (CPB) @(negedge clk);
            check("mon_stop_bit", tx0, 1);
            check("mon_byte_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("mon_byte", mon_byte, exp_q.pop_front());
            mon_seen++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    vec_t vecs[7];
    bq_t  q6;
    bq_t  q4;
    bq_t  q1;
    int   w;
    int   gap;
    int   k;

    initial begin
        vecs[0] = '{1'b0, 8'hA5, 11'h34A, 10};
        vecs[1] = '{1'b1, 8'h07, 11'h60E, 11};
        vecs[2] = '{1'b1, 8'h03, 11'h406, 11};
        vecs[3] = '{1'b0, 8'h00, 11'h200, 10};
        vecs[4] = '{1'b0, 8'hFF, 11'h3FE, 10};
        vecs[5] = '{1'b1, 8'h80, 11'h700, 11};
        vecs[6] = '{1'b1, 8'h3C, 11'h478, 11};

        // Reset state, during and after reset.
        repeat (3) @(negedge clk);
        check("rst_tx0", tx0, 1);       check("rst_busy0", busy0, 0);
        check("rst_cnt0", cnt0, 0);     check("rst_ready0", ready0, 1);
        check("rst_tx1", tx1, 1);       check("rst_cnt1", cnt1, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_tx0", tx0, 1);      check("idle_busy0", busy0, 0);
        check("idle_busy1", busy1, 0);  check("idle_ready1", ready1, 1);

        // Single frames against constant line images, exact latency and length.
        for (int i = 0; i < 7; i++) begin
            sel = vecs[i].s;
            @(negedge clk);
            push1(vecs[i].data);
            check($sformatf("vec%0d_tx_before_start", i), tx_s, 1);
            check($sformatf("vec%0d_count", i), cnt_s, 1);
            check($sformatf("vec%0d_busy", i), busy_s, 1);
            @(negedge clk);
            for (int j = 0; j < vecs[i].nbits * CPB; j++) begin
                check($sformatf("vec%0d_bit%0d", i, j / CPB), tx_s, vecs[i].bits[j / CPB]);
                @(negedge clk);
            end
            check($sformatf("vec%0d_end_tx", i), tx_s, 1);
            check($sformatf("vec%0d_end_busy", i), busy_s, 0);
            check($sformatf("vec%0d_end_count", i), cnt_s, 0);
            check($sformatf("vec%0d_end_ready", i), ready_s, 1);
        end

        // Six bytes with i_valid held: fill to full, full+pop without a write, contiguous frames.
        sel = 1'b0;
        @(negedge clk);
        q6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    w = 0;
                    tb_data  = q6[i];
                    tb_valid = 1'b1;
                    while (!ready_s && w < 100) begin
                        @(negedge clk);
                        w++;
                    end
                    if (i == 5) begin
                        check("full_wait_cycles", w, 37);
                        check("count_after_full_pop", cnt_s, 3);
                    end
                    @(posedge clk);
                    @(negedge clk);
                    if (i == 4) begin
                        check("count_at_full", cnt_s, 4);
                        check("ready_at_full", ready_s, 0);
                    end
                end
                tb_valid = 1'b0;
            end
            expect_frames(q6, 1'b0, 20);
        join
        check("burst6_end_tx", tx_s, 1);
        check("burst6_end_busy", busy_s, 0);

        // Push and pop on the same edge at count 2.
        @(negedge clk);
        q4 = '{8'hC3, 8'h5A, 8'h0F, 8'hE1};
        fork
            begin
                push1(q4[0]);
                push1(q4[1]);
                push1(q4[2]);
                check("count_two", cnt_s, 2);
                repeat (38) @(negedge clk);
                push1(q4[3]);
                check("count_two_pushpop", cnt_s, 2);
            end
            expect_frames(q4, 1'b0, 20);
        join
        check("seq4_end_busy", busy_s, 0);

        // Reset in the middle of data bit 3.
        @(negedge clk);
        push1(8'h00);
        push1(8'h00);
        push1(8'h55);
        repeat (17) @(negedge clk);
        check("pre_reset_d3_low", tx0, 0);
        check("pre_reset_count", cnt0, 2);
        check("pre_reset_busy", busy0, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_reset_tx", tx0, 1);
        check("mid_reset_count", cnt0, 0);
        check("mid_reset_busy", busy0, 0);
        check("mid_reset_ready", ready0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_tx", tx0, 1);
        check("post_reset_busy", busy0, 0);
        q1 = '{8'h96};
        push1(8'h96);
        expect_frames(q1, 1'b0, 4);
        check("post_reset_frame_busy", busy0, 0);
        check("post_reset_frame_count", cnt0, 0);

        // Randomized stream with random gaps, decoded by the monitor.
        mon_en = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            tb_data  = 8'($urandom);
            tb_valid = 1'b1;
            w = 0;
            while (!ready0 && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (!ready0) check("rand_accept_bound", w, 0);
            @(posedge clk);
            exp_q.push_back(tb_data);
            @(negedge clk);
            tb_valid = 1'b0;
        end
        k = 0;
        while ((exp_q.size() != 0 || busy0 !== 1'b0) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("rand_queue_drained", exp_q.size(), 0);
        check("rand_bytes_decoded", mon_seen, 1000);
        check("rand_end_busy", busy0, 0);
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
